// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus field widths, R/W convention and the
// target state encoding, common to i2c_slave and i2c_master.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;

   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_WR_BYTE,
      S_WR_ACK,
      S_RD_BYTE,
      S_RD_ACK,
      S_IGNORE
   } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus one history flop for an I2C bus line;
// flags one-clk rise/fall pulses on the synchronized level.
module i2c_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [2:0] sh;

   // idle bus is pulled high, so reset to 1 to avoid a false edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sh <= 3'b111;
      else       sh <= {sh[1:0], din};
   end

   assign level = sh[1];
   assign rise  = sh[1] & ~sh[2];
   assign fall  = ~sh[1] & sh[2];

endmodule

// File: rtl/i2c_slave.sv
// I2C target answering one 7-bit address; oversamples SCL/SDA,
// never stretches SCL, drives SDA open-drain.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h42
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  scl,
   inout  wire                   sda,
   output logic [I2C_BYTE_W-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  tx_req,
   input  logic [I2C_BYTE_W-1:0] tx_data,
   output logic                  addressed,
   output logic                  rw,
   output logic                  nack_seen
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_det, stop_det;

   i2c_state_t state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [I2C_BYTE_W-1:0] shreg_q, shreg_d;
   logic [I2C_BYTE_W-1:0] tx_byte_q, tx_byte_d;
   logic [I2C_BYTE_W-1:0] rx_data_d;
   logic rx_valid_d, tx_req_d, nack_d;
   logic addressed_d, rw_d;
   logic drive_q, drive_d;
   logic armed_q, armed_d;

   i2c_line_sync u_scl_sync (
      .clk   (clk),
      .reset (reset),
      .din   (scl),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .clk   (clk),
      .reset (reset),
      .din   (sda),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   assign sda = drive_q ? 1'b0 : 1'bz;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= 3'd7;
         shreg_q   <= '0;
         tx_byte_q <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         nack_seen <= 1'b0;
         addressed <= 1'b0;
         rw        <= 1'b0;
         drive_q   <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         tx_byte_q <= tx_byte_d;
         rx_data   <= rx_data_d;
         rx_valid  <= rx_valid_d;
         tx_req    <= tx_req_d;
         nack_seen <= nack_d;
         addressed <= addressed_d;
         rw        <= rw_d;
         drive_q   <= drive_d;
         armed_q   <= armed_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      tx_byte_d   = tx_byte_q;
      rx_data_d   = rx_data;
      rx_valid_d  = 1'b0;
      tx_req_d    = 1'b0;
      nack_d      = 1'b0;
      addressed_d = addressed;
      rw_d        = rw;
      drive_d     = drive_q;
      armed_d     = armed_q;

      // the tx byte is captured the clk after tx_req; mid-read it goes
      // straight onto the bus as bit 7
      if (tx_req) begin
         tx_byte_d = tx_data;
         if (state_q == S_RD_BYTE) drive_d = ~tx_data[7];
      end

      if (start_det) begin
         state_d   = S_ADDR;
         bit_cnt_d = 3'd7;
         drive_d   = 1'b0;
         armed_d   = 1'b0;
      end else if (stop_det) begin
         state_d     = S_IDLE;
         drive_d     = 1'b0;
         addressed_d = 1'b0;
      end else begin
         unique case (state_q)
            S_ADDR: begin
               // the SCL fall that closes START precedes any bit
               if (scl_rise) begin
                  shreg_d = {shreg_q[6:0], sda_lvl};
                  armed_d = 1'b1;
               end else if (scl_fall && armed_q) begin
                  if (bit_cnt_q == 3'd0) begin
                     bit_cnt_d = 3'd7;
                     if (shreg_q[7:1] == SLAVE_ADDR) begin
                        state_d     = S_ADDR_ACK;
                        drive_d     = 1'b1;
                        addressed_d = 1'b1;
                        rw_d        = shreg_q[0];
                        tx_req_d    = (shreg_q[0] == I2C_RW_READ);
                     end else begin
                        state_d     = S_IGNORE;
                        addressed_d = 1'b0;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = 3'd7;
                  if (rw == I2C_RW_READ) begin
                     state_d = S_RD_BYTE;
                     drive_d = ~tx_byte_q[7];
                  end else begin
                     state_d = S_WR_BYTE;
                     drive_d = 1'b0;
                  end
               end
            end
            S_WR_BYTE: begin
               if (scl_rise) begin
                  shreg_d = {shreg_q[6:0], sda_lvl};
               end else if (scl_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     state_d    = S_WR_ACK;
                     bit_cnt_d  = 3'd7;
                     rx_data_d  = shreg_q;
                     rx_valid_d = 1'b1;
                     drive_d    = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end
            end
            S_WR_ACK: begin
               if (scl_fall) begin
                  state_d   = S_WR_BYTE;
                  bit_cnt_d = 3'd7;
                  drive_d   = 1'b0;
               end
            end
            S_RD_BYTE: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     state_d   = S_RD_ACK;
                     bit_cnt_d = 3'd7;
                     drive_d   = 1'b0;
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                     drive_d   = ~tx_byte_q[bit_cnt_q - 3'd1];
                  end
               end
            end
            S_RD_ACK: begin
               if (scl_rise && sda_lvl) begin
                  state_d = S_IGNORE;
                  nack_d  = 1'b1;
               end else if (scl_fall) begin
                  state_d   = S_RD_BYTE;
                  bit_cnt_d = 3'd7;
                  tx_req_d  = 1'b1;
               end
            end
            S_IDLE: ;
            S_IGNORE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave with random transfers,
// checked against a transaction-level model of the target.
module tb_i2c_slave;

   localparam int Q = 8;
   localparam logic [6:0] ADDR = 7'h42;

   logic       clk = 1'b0;
   logic       reset;
   logic       scl;
   logic       m_sda_low;
   wire        sda_bus;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_req;
   logic [7:0] tx_data;
   logic       addressed;
   logic       rw;
   logic       nack_seen;

   assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   always #5 clk = ~clk;

   i2c_slave dut (
      .clk       (clk),
      .reset     (reset),
      .scl       (scl),
      .sda       (sda_bus),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_req    (tx_req),
      .tx_data   (tx_data),
      .addressed (addressed),
      .rw        (rw),
      .nack_seen (nack_seen)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [7:0] rx_q[$];
   logic [7:0] serve_q[$];
   int n_txreq = 0;
   int n_nack = 0;
   int exp_txreq = 0;
   int exp_nack = 0;
   logic [7:0] last_rx = 8'h00;

   always @(negedge clk) begin
      if (rx_valid) rx_q.push_back(rx_data);
      if (nack_seen) n_nack++;
      if (tx_req) begin
         n_txreq++;
         if (serve_q.size() > 0) tx_data = serve_q.pop_front();
         else tx_data = 8'($urandom);
      end
   end

   task automatic qw();
      repeat (Q) @(posedge clk);
   endtask

   task automatic i2c_start();
      m_sda_low = 1'b0; qw();
      scl = 1'b1; qw();
      m_sda_low = 1'b1; qw();
      scl = 1'b0; qw();
   endtask

   task automatic i2c_stop();
      m_sda_low = 1'b1; qw();
      scl = 1'b1; qw();
      m_sda_low = 1'b0; qw(); qw();
   endtask

   task automatic send_bit(input logic b);
      m_sda_low = ~b; qw();
      scl = 1'b1; qw(); qw();
      scl = 1'b0; qw();
   endtask

   task automatic recv_bit(output logic b);
      m_sda_low = 1'b0; qw();
      scl = 1'b1; qw();
      b = sda_bus; qw();
      scl = 1'b0; qw();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic nack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      recv_bit(nack);
   endtask

   task automatic read_byte(output logic [7:0] b, input logic ack);
      for (int i = 7; i >= 0; i--) recv_bit(b[i]);
      send_bit(~ack);
   endtask

   task automatic check_rx(input logic [7:0] exp[$]);
      chk("rx_count", rx_q.size(), exp.size());
      foreach (exp[i]) begin
         if (rx_q.size() > 0) chk("rx_byte", rx_q.pop_front(), exp[i]);
      end
      rx_q.delete();
      chk("rx_hold", rx_data, last_rx);
   endtask

   task automatic xfer(input logic [6:0] a, input logic rd,
                       input int n, input logic do_stop,
                       input logic [7:0] fixed, input logic use_fixed);
      logic nk;
      logic [7:0] b;
      logic [7:0] exp_tx[$];
      logic [7:0] exp_rx[$];
      bit hit;
      hit = (a == ADDR);
      if (hit && rd) begin
         for (int i = 0; i < n; i++) begin
            b = use_fixed && i == 0 ? fixed : 8'($urandom);
            exp_tx.push_back(b);
            serve_q.push_back(b);
         end
      end
      i2c_start();
      write_byte({a, rd}, nk);
      chk("addr_ack", nk, hit ? 0 : 1);
      chk("addressed", addressed, hit);
      if (hit) chk("rw", rw, rd);
      if (hit && !rd) begin
         for (int i = 0; i < n; i++) begin
            b = use_fixed && i == 0 ? fixed : 8'($urandom);
            write_byte(b, nk);
            chk("wr_ack", nk, 0);
            exp_rx.push_back(b);
            last_rx = b;
         end
      end
      if (hit && rd) begin
         for (int i = 0; i < n; i++) begin
            read_byte(b, i < n - 1);
            chk("rd_data", b, exp_tx[i]);
         end
         exp_txreq += n;
         exp_nack += 1;
      end
      if (do_stop) begin
         i2c_stop();
         chk("addr_after_stop", addressed, 0);
         chk("sda_idle", sda_bus, 1);
      end
      check_rx(exp_rx);
      chk("txreq_cnt", n_txreq, exp_txreq);
      chk("nack_cnt", n_nack, exp_nack);
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_sda"}, sda_bus, 1);
      chk({tag, "_rx_data"}, rx_data, 0);
      chk({tag, "_rx_valid"}, rx_valid, 0);
      chk({tag, "_tx_req"}, tx_req, 0);
      chk({tag, "_addressed"}, addressed, 0);
      chk({tag, "_rw"}, rw, 0);
      chk({tag, "_nack"}, nack_seen, 0);
   endtask

   initial begin
      logic nk;
      reset = 1'b1;
      scl = 1'b1;
      m_sda_low = 1'b0;
      tx_data = 8'h00;
      repeat (4) @(posedge clk);
      #1 check_reset_outs("reset");
      reset = 1'b0;
      qw();

      xfer(ADDR, 1'b0, 1, 1'b1, 8'hA5, 1'b1);
      xfer(7'h43, 1'b0, 1, 1'b1, 8'h00, 1'b0);
      xfer(ADDR, 1'b1, 2, 1'b1, 8'h3C, 1'b1);
      serve_q.delete();
      xfer(ADDR, 1'b0, 1, 1'b0, 8'h10, 1'b1);
      xfer(ADDR, 1'b1, 1, 1'b1, 8'h77, 1'b1);

      i2c_start();
      write_byte({ADDR, 1'b0}, nk);
      for (int i = 7; i > 3; i--) send_bit(i[0]);
      i2c_stop();
      check_rx('{});
      chk("stop_mid_addr", addressed, 0);

      i2c_start();
      for (int i = 7; i >= 1; i--) send_bit(ADDR[i - 1]);
      send_bit(1'b0);
      m_sda_low = 1'b0;
      qw();
      chk("ack_driven", sda_bus, 0);
      reset = 1'b1;
      #1 check_reset_outs("rst_ack");
      @(posedge clk);
      reset = 1'b0;
      last_rx = 8'h00;
      qw();

      i2c_start();
      write_byte({ADDR, 1'b0}, nk);
      for (int i = 7; i > 3; i--) send_bit(i[1]);
      scl = 1'b1;
      m_sda_low = 1'b0;
      repeat (3) @(posedge clk);
      reset = 1'b1;
      #1 check_reset_outs("rst_data");
      @(posedge clk);
      reset = 1'b0;
      scl = 1'b0;
      qw();
      rx_q.delete();
      xfer(ADDR, 1'b0, 1, 1'b1, 8'h5A, 1'b1);

      for (int t = 0; t < 20; t++) begin
         logic [6:0] a;
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR;
         xfer(a, 1'($urandom), int'($urandom_range(1, 3)),
              1'($urandom), 8'h00, 1'b0);
      end
      i2c_stop();
      chk("final_addr", addressed, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (slave) that answers a single 7-bit address on the open-drain bus driven by the team's I2C master. It supports master-write (bytes delivered on a valid-pulse interface) and master-read (bytes fetched through a request/data interface). It oversamples SCL/SDA on the system clock and never stretches SCL. It sits between the board I2C pins and local register/FIFO logic.

## Interface
- `SLAVE_ADDR`, 7'h42, 7-bit address this target ACKs.
- `clk`  in  1  system clock, ≥ 16× SCL frequency.
- `reset`  in  1  asynchronous, active-high.
- `scl`  in  1  bus clock; input only, never driven.
- `sda`  inout  1  open-drain: driven `1'b0` when `sda_drive_low`, else `1'bz`.
- `rx_data`  out  8  last byte written by master.
- `rx_valid`  out  1  one-clk pulse, `rx_data` valid.
- `tx_req`  out  1  one-clk pulse: next read byte needed.
- `tx_data`  in  8  byte to send; sampled on the clk after `tx_req`.
- `addressed`  out  1  high from address-ACK to STOP or non-matching START.
- `rw`  out  1  R/W bit of current transfer (1 = master read).
- `nack_seen`  out  1  one-clk pulse when master NACKs a read byte.

## Operation
- SCL/SDA each pass through a 2-FF synchronizer plus 1 history flop. Rise/fall flags are derived from the last two synced samples.
- START: SDA fall while synced SCL high. STOP: SDA rise while SCL high. Both are recognised in every state and take priority over bit handling.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- IDLE → ADDR on START. START in any state → ADDR (repeated start), `bit_cnt`=7, SDA released. STOP in any state → IDLE, SDA released, `addressed`=0.
- ADDR: shift SDA on each SCL rise, MSB first; 8 bits, the 8th is R/W.
  - After the 8th SCL fall: if address matches → ADDR_ACK, drive SDA low, latch `rw`, `addressed`=1.
  - Otherwise → IGNORE (SDA never driven until START/STOP).
  - If `rw`=1, `tx_req` pulses at this same SCL fall.
- ADDR_ACK: on the next SCL fall, release SDA, then go to WR_BYTE (`rw`=0) or RD_BYTE (`rw`=1).
  - For RD_BYTE: drive `tx_data[7]` (low if 0, released if 1) on that fall.
- WR_BYTE: 8 bits sampled on SCL rise.
  - On the 8th SCL fall: `rx_data` ← byte, `rx_valid` pulse, drive ACK (low) → WR_ACK.
  - WR_ACK: release SDA on the next SCL fall → WR_BYTE. Writes are always ACKed.
- RD_BYTE: on each SCL fall, shift out the next bit of the latched tx byte.
  - After the 8th bit's SCL fall, release SDA → RD_ACK.
- RD_ACK: sample SDA on SCL rise.
  - 0 (ACK): `tx_req` pulse on the SCL fall, go to RD_BYTE, drive new bit 7.
  - 1 (NACK): `nack_seen` pulse, go to IGNORE.
- `bit_cnt` is 3 bits, counts 7→0, and is reloaded to 7 on START and on every ACK-slot exit.

## Timing
- Reset (async) values: `sda` released, state IDLE, `rx_data`=0, `rx_valid`=0, `tx_req`=0, `addressed`=0, `rw`=0, `nack_seen`=0.
- Pin-to-detection latency is 3 clk. SDA output changes 1 clk after the detected SCL fall, i.e. ≤4 clk after the pin edge. The master's quarter-period tick must exceed 4 clk.
- `tx_req` to sample: `tx_data` is latched exactly 1 clk after the `tx_req` pulse. Bit 7 is driven in the same clk it is latched.
- `rx_valid` asserts 1 clk after the 8th data SCL fall is detected; `rx_data` then holds until the next byte.
- Simultaneous START/STOP flag with a SCL edge cannot occur (SCL is high during both). If a STOP arrives mid-byte, the partial byte is discarded with no `rx_valid`.
- Reset mid-transfer: SDA released in the same cycle (async). After release the target waits in IDLE for a fresh START.

## Structure
- Package `i2c_pkg`: state encodings, `I2C_ADDR_W`=7, `I2C_BYTE_W`=8, and the R/W bit convention, all shared with `i2c_master`.
- Sub-module `i2c_line_sync`: 2-FF synchronizer plus edge detector, instantiated for SCL and SDA. Outputs `level`, `rise`, `fall`.

## Test plan
- Master write to 0x42, data 0xA5 → address ACK low, data ACK low, one `rx_valid` with `rx_data`=0xA5, `rw`=0; then STOP → `addressed`=0.
- Master write to 0x43 → address slot reads 1 (NACK), master `ack_err`=1, no `rx_valid`, SDA never driven low by target.
- Master read from 0x42 with `tx_data`=0x3C then 0xC3, master ACK then NACK → master receives 0x3C, 0xC3; `tx_req` pulses ×2; one `nack_seen`; SDA released.
- Write 0x42 + byte 0x10, repeated START, read 0x42 with `tx_data`=0x77 → `rx_data`=0x10, read returns 0x77, `rw` changes 0→1, `addressed` stays high.
- Assert `reset` mid-way through write data bit 3 → SDA released immediately, all outputs 0; a following full write of 0x5A succeeds with `rx_data`=0x5A.
- STOP after 4 data bits of a write → no `rx_valid`, state IDLE, `rx_data` unchanged from its previous value.
